q_measure: RTL and testbench
============================

Name: q_measure

Overview:
- Produces the `q_measured` / `ready` pair that the instability sweep consumes. It sits on the other side of the `i_ref_setup` handshake.
- Each time the sweep changes the reference current, the block waits a settling interval. It then averages a fixed number of amplitude samples and presents the result with a one-cycle `ready` pulse.
- The sweep decrements its reference on each pulse, which closes the measure/step loop.

Parameters:
- BUS_WIDTH, 10, width of `i_ref` and `q_measured`; must match the sweep block.
- SAMPLE_WIDTH, 10, width of the incoming amplitude sample; must be <= BUS_WIDTH.
- SETTLE_CYCLES, 64, clocks to wait after a reference change before sampling; must be >= 1.
- AVG_LOG2, 3, log2 of the number of samples averaged per measurement (8 by default).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  measurement loop enable; shared with the sweep block.
- i_ref  in  BUS_WIDTH  reference current from the sweep; a change triggers a new measurement.
- sample_valid  in  1  qualifies `sample` for one clock.
- sample  in  SAMPLE_WIDTH  amplitude sample from the front end.
- q_measured  out  BUS_WIDTH  averaged Q result; registered; holds between measurements.
- ready  out  1  one-clock pulse, asserted in the cycle `q_measured` is valid with a new value.
- busy  out  1  high while in SETTLE or ACCUM.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE; `q_measured` = 0; `ready` = 0; `busy` = 0.
  - Accumulator, sample counter and settle counter = 0.
  - `ref_last` = 0; `start_pending` = 1.
- Internal registers:
  - `ref_last` holds the `i_ref` value the current or last measurement belongs to.
  - `start_pending` forces a measurement on the first enabled cycle.
- State IDLE:
  - Leave to SETTLE when `enable` is high and either `start_pending` = 1 or `i_ref` != `ref_last`.
  - On entry to SETTLE: capture `ref_last` <= `i_ref`, clear `start_pending`, load the settle counter with SETTLE_CYCLES-1.
- State SETTLE:
  - Counter decrements each clock. When it reads 0, go to ACCUM.
  - On entry to ACCUM: clear the accumulator and sample counter.
  - `sample_valid` is ignored in SETTLE.
- State ACCUM:
  - On each `sample_valid`, acc <= acc + sample and the sample counter increments.
  - Accumulator width is SAMPLE_WIDTH+AVG_LOG2, so it cannot overflow.
  - When the 2**AVG_LOG2-th sample is accepted, go to DONE.
- State DONE (one cycle):
  - `q_measured` <= acc >> AVG_LOG2, zero-extended to BUS_WIDTH, truncating average.
  - `ready` = 1 registered, so it is high in the cycle after the DONE entry edge and for exactly one clock.
  - Next state is IDLE.
- Latency from a detected `i_ref` change to the `ready` pulse:
  - SETTLE_CYCLES + (clocks to collect 2**AVG_LOG2 valid samples) + 2, with samples valid every cycle.
- Reference change mid-measurement (`i_ref` != `ref_last` while in SETTLE or ACCUM):
  - Abort and restart SETTLE with the new `i_ref` captured.
  - The accumulator is discarded, no `ready` is issued, and `q_measured` is unchanged.
- Enable dropped:
  - Any state returns to IDLE next clock; `ready` stays 0 and `busy` goes to 0.
  - `start_pending` is set, so re-enable always triggers a fresh measurement even with `i_ref` unchanged.
  - `q_measured` holds its last value.
- Simultaneous events:
  - `enable` low takes priority over an `i_ref` change.
  - An `i_ref` change in the same cycle as the final `sample_valid` aborts the measurement; no `ready` is issued.
- Held reference: a DONE followed by an unchanged `i_ref` leaves the block in IDLE with no further pulses.
- Reset mid-operation: all state clears immediately; no partial `ready` pulse.
- `busy` is a combinational decode of state (SETTLE or ACCUM); `ready` and `q_measured` are registered.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=0, SETTLE=1, ACCUM=2, DONE=3);
  - the default BUS_WIDTH, common with the sweep block;
  - the helper constant NUM_SAMPLES = 2**AVG_LOG2.
- One natural sub-module: `q_avg_accum`. It contains the accumulator, the sample counter and the shift-average, with `clear` / `add` / `last` handshake signals. The FSM stays in the top level.

Test Plan:
- Bench uses SETTLE_CYCLES=4, AVG_LOG2=2.
- Reset then enable=1, i_ref=1023, sample=100 valid every cycle -> `ready` pulses once 4+4+2 clocks after enable; `q_measured`=100; `busy` high for 8 clocks.
- Samples 10, 11, 12, 14 (sum 47) -> `q_measured`=11 (truncation); one `ready` pulse.
- After DONE, hold i_ref=1023 for 50 clocks -> no further `ready`. Step i_ref to 973 -> new measurement, `ready` after 10 clocks.
- Change i_ref 973 -> 923 while in ACCUM after 2 samples -> no `ready` for the old measurement. SETTLE restarts; `ready` arrives 10 clocks after the change; `q_measured` unchanged until then.
- Drop enable during SETTLE, then re-raise with i_ref unchanged -> `busy` goes 0 next clock; on re-enable a full measurement runs and `ready` pulses.
- Assert rst=0 asynchronously mid-ACCUM with `q_measured`=100 -> `q_measured`=0, `ready`=0 and `busy`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/q_measure_pkg.sv
// Shared definitions for the Q measurement block and its sweep partner:
// state encoding, default bus width and the sample-count helper.
package q_measure_pkg;

    // Common with the sweep block; both sides of i_ref/q_measured must agree.
    localparam int BUS_WIDTH_DEF   = 10;
    localparam int AVG_LOG2_DEF    = 3;
    localparam int NUM_SAMPLES_DEF = 2 ** AVG_LOG2_DEF;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_ACCUM  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Number of samples averaged per measurement.
    function automatic int num_samples(input int avg_log2);
        return 2 ** avg_log2;
    endfunction

endpackage

// File: rtl/q_avg_accum.sv
// Sample accumulator for q_measure: sums 2**AVG_LOG2 samples and presents
// the truncating average. The controlling FSM drives clear/add and watches
// last to know when the final sample is being taken.
module q_avg_accum
    import q_measure_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 10,
    parameter int AVG_LOG2     = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    add,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    output logic                    last,
    output logic [SAMPLE_WIDTH-1:0] avg
);

    // Wide enough to hold the full sum, so no overflow handling is needed.
    localparam int ACC_W = SAMPLE_WIDTH + AVG_LOG2;
    // One spare bit keeps the counter legal when AVG_LOG2 is 0.
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int NUM   = num_samples(AVG_LOG2);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    // Sum accepted samples and count them; clear wins over add.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (add) begin
            acc <= acc + ACC_W'(sample);
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign last = add && (cnt == CNT_W'(NUM - 1));
    assign avg  = acc[ACC_W-1:AVG_LOG2];

endmodule

// File: rtl/q_measure.sv
// Q measurement controller. Waits for the reference current to settle after
// each change, averages a burst of amplitude samples, and hands the result
// to the sweep with a one-clock ready pulse.
//
//   state  | meaning
//   IDLE   | waiting for enable plus a new reference (or a forced start)
//   SETTLE | settle down-counter running; samples ignored
//   ACCUM  | summing valid samples until the burst is complete
//   DONE   | one cycle: publish average, pulse ready
module q_measure
    import q_measure_pkg::*;
#(
    parameter int BUS_WIDTH     = BUS_WIDTH_DEF,
    parameter int SAMPLE_WIDTH  = 10,
    parameter int SETTLE_CYCLES = 64,
    parameter int AVG_LOG2      = AVG_LOG2_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [BUS_WIDTH-1:0]    i_ref,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    output logic [BUS_WIDTH-1:0]    q_measured,
    output logic                    ready,
    output logic                    busy
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

    state_t                  state;
    logic [BUS_WIDTH-1:0]    ref_last;
    logic                    start_pending;
    logic [SET_W-1:0]        settle_cnt;

    logic                    ref_changed;
    logic                    acc_clear;
    logic                    acc_add;
    logic                    acc_last;
    logic [SAMPLE_WIDTH-1:0] avg;
    logic [BUS_WIDTH-1:0]    avg_ext;

    assign ref_changed = (i_ref != ref_last);
    assign avg_ext     = BUS_WIDTH'(avg);
    assign busy        = (state == ST_SETTLE) || (state == ST_ACCUM);

    // Accumulator handshake: clear on the SETTLE->ACCUM edge, add only while
    // the measurement is still live (enabled, reference unchanged).
    always_comb begin
        acc_clear = 1'b0;
        acc_add   = 1'b0;
        if (enable && !ref_changed) begin
            acc_clear = (state == ST_SETTLE) && (settle_cnt == '0);
            acc_add   = (state == ST_ACCUM) && sample_valid;
        end
    end

    q_avg_accum #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .AVG_LOG2     (AVG_LOG2)
    ) u_avg (
        .clk    (clk),
        .rst    (rst),
        .clear  (acc_clear),
        .add    (acc_add),
        .sample (sample),
        .last   (acc_last),
        .avg    (avg)
    );

    // Measurement sequencer; disable beats a reference change, which beats
    // sample completion, so an aborted burst never reaches DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            ref_last      <= '0;
            start_pending <= 1'b1;
            settle_cnt    <= '0;
            q_measured    <= '0;
            ready         <= 1'b0;
        end else begin
            ready <= 1'b0;
            if (!enable) begin
                state         <= ST_IDLE;
                start_pending <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_pending || ref_changed) begin
                            state         <= ST_SETTLE;
                            ref_last      <= i_ref;
                            start_pending <= 1'b0;
                            settle_cnt    <= SETTLE_LOAD;
                        end
                    end
                    ST_SETTLE: begin
                        if (ref_changed) begin
                            ref_last   <= i_ref;
                            settle_cnt <= SETTLE_LOAD;
                        end else if (settle_cnt == '0) begin
                            state <= ST_ACCUM;
                        end else begin
                            settle_cnt <= settle_cnt - SET_W'(1);
                        end
                    end
                    ST_ACCUM: begin
                        if (ref_changed) begin
                            state      <= ST_SETTLE;
                            ref_last   <= i_ref;
                            settle_cnt <= SETTLE_LOAD;
                        end else if (acc_last) begin
                            state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        q_measured <= avg_ext;
                        ready      <= 1'b1;
                        state      <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_q_measure.sv
// Bench for q_measure with SETTLE_CYCLES=4, AVG_LOG2=2. Expected averages are
// queued when a measurement is launched and popped whenever ready pulses.
module tb_q_measure;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [9:0] i_ref;
    logic       sample_valid;
    logic [9:0] sample;
    logic [9:0] q_measured;
    logic       ready;
    logic       busy;

    q_measure #(
        .BUS_WIDTH     (10),
        .SAMPLE_WIDTH  (10),
        .SETTLE_CYCLES (4),
        .AVG_LOG2      (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .i_ref        (i_ref),
        .sample_valid (sample_valid),
        .sample       (sample),
        .q_measured   (q_measured),
        .ready        (ready),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] r;
        logic [9:0] s0, s1, s2, s3;
        int         q;
        bit         all_valid;
    } vec_t;

    vec_t vecs[5];
    int   exp_q[$];
    int   checks;
    int   errors;
    int   cyc;
    int   ready_count;
    int   ready_cyc;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    // Advance to the next falling edge and score any ready pulse seen there.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rst && ready) begin
            ready_count++;
            ready_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready actual q=%0d required no pulse", q_measured);
            end else begin
                chk("q_measured", int'(q_measured), exp_q.pop_front());
            end
        end
    endtask

    task automatic set_vec(input int i, input logic [9:0] r, input logic [9:0] s0,
                           input logic [9:0] s1, input logic [9:0] s2,
                           input logic [9:0] s3, input int q, input bit av);
        vecs[i].r = r;   vecs[i].s0 = s0; vecs[i].s1 = s1;
        vecs[i].s2 = s2; vecs[i].s3 = s3; vecs[i].q = q; vecs[i].all_valid = av;
    endtask

    // One complete measurement launched at the current falling edge. The four
    // samples land in the four ACCUM cycles (edges 6..9 after the launch).
    // With overlap set, the launch cycle also carries a stray valid sample,
    // used to collide a reference change with a burst's final sample.
    task automatic measure(input string name, input logic [9:0] r,
                           input logic [9:0] s0, input logic [9:0] s1,
                           input logic [9:0] s2, input logic [9:0] s3,
                           input int q, input bit all_valid, input bit overlap);
        int         start_cyc;
        int         busy_n;
        int         rc0;
        logic [9:0] s[4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        enable    = 1'b1;
        i_ref     = r;
        exp_q.push_back(q);
        start_cyc = cyc;
        rc0       = ready_count;
        busy_n    = 0;
        for (int k = 0; k < 12; k++) begin
            if (k >= 5 && k <= 8) begin
                sample_valid = 1'b1;
                sample       = s[k-5];
            end else if (all_valid) begin
                sample_valid = 1'b1;
                sample       = s0;
            end else if (overlap && k == 0) begin
                sample_valid = 1'b1;
                sample       = 10'd999;
            end else begin
                sample_valid = 1'b0;
            end
            tick();
            if (busy) busy_n++;
        end
        sample_valid = 1'b0;
        chk({name, "_ready_count"}, ready_count - rc0, 1);
        chk({name, "_latency"}, ready_cyc - start_cyc, 10);
        chk({name, "_busy_cycles"}, busy_n, 8);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; ready_count = 0; ready_cyc = -1;
        rst = 1'b0; enable = 1'b0; i_ref = '0; sample_valid = 1'b0; sample = '0;

        set_vec(0, 10'd1023, 10'd100, 10'd100, 10'd100, 10'd100, 100, 1'b1);
        set_vec(1, 10'd1013, 10'd10, 10'd11, 10'd12, 10'd14, 11, 1'b0);
        set_vec(2, 10'd1003, 10'd1023, 10'd1023, 10'd1023, 10'd1023, 1023, 1'b0);
        set_vec(3, 10'd993, 10'd1, 10'd2, 10'd3, 10'd5, 2, 1'b0);
        set_vec(4, 10'd1023, 10'd7, 10'd0, 10'd0, 10'd0, 1, 1'b0);

        repeat (3) tick();
        chk("reset_q", int'(q_measured), 0);
        chk("reset_ready", int'(ready), 0);
        chk("reset_busy", int'(busy), 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 5; i++)
            measure($sformatf("vec%0d", i), vecs[i].r, vecs[i].s0, vecs[i].s1,
                    vecs[i].s2, vecs[i].s3, vecs[i].q, vecs[i].all_valid, 1'b0);

        // Held reference: no further pulses, block stays idle.
        begin
            int rc0;
            int busy_n;
            rc0 = ready_count; busy_n = 0;
            repeat (50) begin
                tick();
                if (busy) busy_n++;
            end
            chk("hold_ready_count", ready_count - rc0, 0);
            chk("hold_busy_cycles", busy_n, 0);
        end

        measure("step_973", 10'd973, 10'd50, 10'd50, 10'd50, 10'd50, 50, 1'b0, 1'b0);

        // Abort in ACCUM after two samples; result must stay at 50.
        i_ref = 10'd948;
        for (int k = 0; k < 7; k++) begin
            sample_valid = (k >= 5);
            sample       = 10'd200;
            tick();
        end
        chk("abort_q_held", int'(q_measured), 50);
        chk("abort_busy", int'(busy), 1);
        measure("abort_restart", 10'd923, 10'd60, 10'd60, 10'd60, 10'd60, 60, 1'b0, 1'b0);

        // Reference change in the same cycle as the final sample.
        i_ref = 10'd850;
        for (int k = 0; k < 8; k++) begin
            sample_valid = (k >= 5);
            sample       = 10'd300;
            tick();
        end
        measure("final_collide", 10'd840, 10'd20, 10'd24, 10'd28, 10'd33, 26, 1'b0, 1'b1);

        // Drop enable in SETTLE, re-enable with the reference unchanged.
        i_ref = 10'd898;
        repeat (2) tick();
        enable = 1'b0;
        tick();
        chk("disable_busy_next", int'(busy), 0);
        begin
            int rc0;
            rc0 = ready_count;
            repeat (4) tick();
            chk("disable_busy_idle", int'(busy), 0);
            chk("disable_no_ready", ready_count - rc0, 0);
        end
        chk("disable_q_held", int'(q_measured), 26);
        measure("reenable", 10'd898, 10'd40, 10'd41, 10'd42, 10'd43, 41, 1'b0, 1'b0);

        // Disable and reference change together: disable wins.
        i_ref = 10'd878;
        repeat (2) tick();
        enable = 1'b0;
        i_ref  = 10'd868;
        tick();
        chk("prio_busy_next", int'(busy), 0);
        measure("prio_reenable", 10'd868, 10'd5, 10'd6, 10'd7, 10'd8, 6, 1'b0, 1'b0);

        // Asynchronous reset mid-ACCUM.
        measure("pre_reset", 10'd1023, 10'd100, 10'd100, 10'd100, 10'd100, 100, 1'b1, 1'b0);
        i_ref        = 10'd1013;
        sample_valid = 1'b1;
        sample       = 10'd100;
        repeat (7) tick();
        chk("pre_reset_q", int'(q_measured), 100);
        chk("pre_reset_busy", int'(busy), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_q", int'(q_measured), 0);
        chk("async_reset_ready", int'(ready), 0);
        chk("async_reset_busy", int'(busy), 0);
        sample_valid = 1'b0;
        repeat (2) tick();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
